silu_arbiter: RTL and testbench
===============================

# silu_arbiter

Shares one pipelined `silu` unit between `N_REQ` requesting engines. Arbitration is round-robin and a grant lasts for a whole burst. Each element's requester ID and last flag travel in a tag FIFO, so every SiLU result returns to its originator. The block sits between the per-layer activation clients and the single `silu` instance. It drives that instance's `a_tvalid`/`a_tdata` and consumes its `result_tvalid`/`result_tdata`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: word width. bf16 sits in [31:16] and [15:0] is zero, matching the `silu` input format.
- `TAG_DEPTH`, 32: tag FIFO depth, a power of two. Must be ≥ `silu` latency + 2.
- `ID_W`, $clog2(N_REQ): requester ID width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset. The top level drives `silu.rst_n = ~rst`.
- `req_valid`  in  N_REQ  per-requester element valid.
- `req_data`  in  N_REQ*DATA_W  requester i occupies [i*DATA_W +: DATA_W].
- `req_last`  in  N_REQ  marks the final element of a burst.
- `req_ready`  out  N_REQ  per-requester accept.
- `silu_a_tvalid`  out  1  to `silu.a_tvalid`.
- `silu_a_tdata`  out  DATA_W  to `silu.a_tdata`.
- `silu_result_tvalid`  in  1  from `silu.result_tvalid`.
- `silu_result_tdata`  in  DATA_W  from `silu.result_tdata`.
- `resp_valid`  out  1  result valid. There is no backpressure; receivers must always accept.
- `resp_id`  out  ID_W  requester the result belongs to.
- `resp_data`  out  DATA_W  SiLU result.
- `resp_last`  out  1  result corresponds to an input that had `req_last`.
- `busy`  out  1  FSM in BURST, or tags outstanding.
- `err_underflow`  out  1  sticky: a result arrived while the tag FIFO was empty.

## Operation
- FSM states are IDLE and BURST.
- **IDLE**
  - Scan requesters starting at `(last_grant+1) mod N_REQ` and choose the first with `req_valid` high.
  - Register `grant` and go to BURST.
  - If no requester is valid, stay in IDLE.
  - All `req_ready` are 0 in IDLE.
- **BURST**
  - `req_ready[grant] = (tag_count < TAG_DEPTH)`. All other `req_ready` are 0.
  - A handshake is `req_valid[grant] & req_ready[grant]`.
  - On a handshake, push `{grant, req_last[grant]}` into the tag FIFO in the same cycle. Also register `silu_a_tvalid <= 1` and `silu_a_tdata <= req_data[grant]`.
  - Without a handshake, register `silu_a_tvalid <= 0` and hold `silu_a_tdata`.
  - A handshake with `req_last` set moves the FSM to IDLE and sets `last_grant <= grant`.
  - Gaps in `req_valid` inside a burst are allowed. The grant is held until the last element.
- **Result path**
  - On `silu_result_tvalid` with the FIFO non-empty: pop the FIFO and register `resp_valid=1`, `resp_id=tag.id`, `resp_last=tag.last`, `resp_data=silu_result_tdata`.
  - On `silu_result_tvalid` with the FIFO empty: set `err_underflow`, drop the result and keep `resp_valid=0`.
- **Tag count**
  - `tag_count` is ID_W-independent and $clog2(TAG_DEPTH)+1 bits wide.
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
  - FIFO read and write pointers wrap modulo TAG_DEPTH.
- **Ordering**
  - `silu` is in-order with fixed latency, so results return in issue order.
  - Per-requester order is preserved.
- **Reset** (asynchronous, including mid-burst)
  - FSM goes to IDLE; `grant=0`; `last_grant=N_REQ-1`, so requester 0 wins first.
  - FIFO is flushed and `tag_count=0`.
  - All outputs return to 0, including `err_underflow`.
  - An interrupted burst is abandoned. The requester must restart it.

## Timing
- The request handshake at cycle t gives `silu_a_tvalid` at t+1.
- A result at cycle r gives `resp_valid` at r+1.
- End-to-end latency is `silu` latency + 2 cycles.
- Arbitration bubble: the last handshake at t gives IDLE at t+1 and the next grant's first possible handshake at t+2.
- Throughput within a burst is 1 element/clk while `tag_count < TAG_DEPTH`.
- All outputs are registered except `req_ready`, which is combinational from the FSM state, `grant` and `tag_count`.

## Test plan
- **Single burst.** Requester 0 sends 4 elements `0x3F80_0000` (1.0), `0x0000_0000`, `0xBF80_0000` (−1.0), `0x4000_0000` (2.0), with last on the 4th.
  - Expect 4 `resp_valid` pulses with `resp_id=0` and `resp_last` only on the 4th.
  - Data must equal the `silu` golden model; 0.0 must give `0x0000_0000`.
- **Round-robin.** Requesters 0, 1 and 3 all hold `req_valid` with 3-element bursts.
  - Grant order is 0, 1, 3, 0.
  - Exactly one idle cycle on `silu_a_tvalid` between bursts.
  - `resp_id` sequence is 0,0,0,1,1,1,3,3,3.
- **Backpressure via tag FIFO.** Use `TAG_DEPTH=4` with a `silu` stub of latency 10 and a 12-element burst.
  - `req_ready` drops after 4 accepts and reasserts the cycle after the first pop.
  - All 12 results return in order; `err_underflow=0`.
- **Simultaneous push/pop.** Stream 64 elements continuously.
  - `tag_count` stays constant at the latency+1 level during steady state.
  - No lost or duplicated responses.
- **Reset mid-burst.** Assert `rst` in the 3rd cycle of a 10-element burst from requester 2.
  - All outputs are 0 immediately; FSM is IDLE.
  - After release, requester 0 wins if it is valid.
- **Underflow.** Force `silu_result_tvalid=1` with an empty FIFO.
  - `err_underflow` becomes 1 and stays 1; `resp_valid` stays 0.

Source files
------------

// File: rtl/silu_arbiter.sv
// Round-robin burst arbiter sharing one pipelined silu unit between N_REQ engines.
// A tag FIFO carries {id,last} per issued element so each result returns to its originator.
module silu_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 32,
   parameter int TAG_DEPTH = 32,
   parameter int ID_W      = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    silu_a_tvalid,
   output logic [DATA_W-1:0]       silu_a_tdata,
   input  logic                    silu_result_tvalid,
   input  logic [DATA_W-1:0]       silu_result_tdata,
   output logic                    resp_valid,
   output logic [ID_W-1:0]         resp_id,
   output logic [DATA_W-1:0]       resp_data,
   output logic                    resp_last,
   output logic                    busy,
   output logic                    err_underflow
);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  grant, grant_nxt;
   logic [ID_W-1:0]  last_grant, last_grant_nxt;
   logic [ID_W-1:0]  scan_id;
   logic             found;
   logic [CNT_W-1:0] tag_count, tag_count_nxt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [ID_W:0]    tag_mem [TAG_DEPTH];
   logic [ID_W:0]    tag_head;
   logic [DATA_W-1:0] grant_data;
   logic             can_push, hs, hs_last, pop, underflow;

   assign can_push  = (tag_count < FULL_CNT);
   assign hs        = (state == BURST) && req_valid[grant] && can_push;
   assign hs_last   = hs && req_last[grant];
   assign pop       = silu_result_tvalid && (tag_count != '0);
   assign underflow = silu_result_tvalid && (tag_count == '0);
   assign tag_head  = tag_mem[rd_ptr];

   always_comb begin
      grant_data = '0;
      for (int r = 0; r < N_REQ; r++) begin
         if (grant == ID_W'(r)) grant_data = req_data[r*DATA_W +: DATA_W];
      end
   end

   // Ready depends only on state, grant and FIFO room, never on req_valid.
   always_comb begin
      req_ready = '0;
      if (state == BURST && can_push) req_ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      found          = 1'b0;
      scan_id        = '0;
      case (state)
         IDLE: begin
            for (int i = 1; i <= N_REQ; i++) begin
               scan_id = ID_W'((int'(last_grant) + i) % N_REQ);
               if (!found && req_valid[scan_id]) begin
                  found     = 1'b1;
                  grant_nxt = scan_id;
                  state_nxt = BURST;
               end
            end
         end
         BURST: begin
            if (hs_last) begin
               state_nxt      = IDLE;
               last_grant_nxt = grant;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tag_count_nxt = tag_count;
      case ({hs, pop})
         2'b10:   tag_count_nxt = tag_count + 1'b1;
         2'b01:   tag_count_nxt = tag_count - 1'b1;
         default: tag_count_nxt = tag_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= LAST_ID;
         tag_count  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         tag_count  <= tag_count_nxt;
         if (hs)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Tag storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (hs) tag_mem[wr_ptr] <= {grant, req_last[grant]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         silu_a_tvalid <= 1'b0;
         silu_a_tdata  <= '0;
         resp_valid    <= 1'b0;
         resp_id       <= '0;
         resp_data     <= '0;
         resp_last     <= 1'b0;
         busy          <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         silu_a_tvalid <= hs;
         if (hs) silu_a_tdata <= grant_data;
         resp_valid <= pop;
         if (pop) begin
            resp_id   <= tag_head[ID_W:1];
            resp_last <= tag_head[0];
            resp_data <= silu_result_tdata;
         end
         if (underflow) err_underflow <= 1'b1;
         busy <= (state_nxt == BURST) || (tag_count_nxt != '0);
      end
   end
endmodule

// File: tb/tb_silu_arbiter.sv
// Directed bench for silu_arbiter with a variable-latency silu stub.
`timescale 1ns/1ps
module tb_silu_arbiter;
   localparam int N_REQ = 4, DATA_W = 32, TAG_DEPTH = 4, ID_W = 2;

   logic clk = 1'b0, rst = 1'b0;
   logic [N_REQ-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [N_REQ*DATA_W-1:0] req_data = '0;
   logic silu_a_tvalid, silu_result_tvalid;
   logic [DATA_W-1:0] silu_a_tdata, silu_result_tdata, resp_data;
   logic resp_valid, resp_last, busy, err_underflow;
   logic [ID_W-1:0] resp_id;

   int checks = 0, fails = 0;
   int cyc = 0;
   int lat = 2;
   logic force_res = 1'b0;

   silu_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .silu_a_tvalid(silu_a_tvalid), .silu_a_tdata(silu_a_tdata),
      .silu_result_tvalid(silu_result_tvalid), .silu_result_tdata(silu_result_tdata),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_last(resp_last),
      .busy(busy), .err_underflow(err_underflow));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // silu stand-in: exact bf16 SiLU for the single-burst vectors, identity otherwise.
   function automatic logic [31:0] silu_ref(input logic [31:0] x);
      case (x)
         32'h3F80_0000: return 32'h3F3B_0000;
         32'hBF80_0000: return 32'hBE8A_0000;
         32'h4000_0000: return 32'h3FE1_0000;
         default:       return x;
      endcase
   endfunction

   logic        pv [16];
   logic [31:0] pd [16];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) pv[k] <= 1'b0;
      end else begin
         pv[0] <= silu_a_tvalid;
         pd[0] <= silu_ref(silu_a_tdata);
         for (int k = 1; k < 16; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
         end
      end
   end
   assign silu_result_tvalid = pv[lat-1] | force_res;
   assign silu_result_tdata  = pd[lat-1];

   int          rid_q[$], rcyc_q[$], hs_id_q[$], hs_cyc_q[$], a_cyc_q[$];
   logic [31:0] rdata_q[$];
   bit          rlast_q[$];
   int          tc_log [8192];
   logic [N_REQ-1:0] rdy_log [8192];

   always @(negedge clk) begin
      if (resp_valid) begin
         rid_q.push_back(int'(resp_id));
         rdata_q.push_back(resp_data);
         rlast_q.push_back(resp_last);
         rcyc_q.push_back(cyc);
      end
      if (silu_a_tvalid) a_cyc_q.push_back(cyc);
      tc_log[cyc % 8192]  <= int'(dut.tag_count);
      rdy_log[cyc % 8192] <= req_ready;
   end

   logic [31:0] dq [N_REQ][$];
   bit          lq [N_REQ][$];

   function automatic logic [31:0] mk(input int r, input int k);
      return {8'(r), 8'(k), 16'h0000};
   endfunction

   task automatic load(input int r, input int n, input int bl);
      for (int k = 0; k < n; k++) begin
         dq[r].push_back(mk(r, k));
         lq[r].push_back((k % bl) == bl - 1);
      end
   endtask

   task automatic clear_logs();
      rid_q.delete(); rcyc_q.delete(); rdata_q.delete(); rlast_q.delete();
      hs_id_q.delete(); hs_cyc_q.delete(); a_cyc_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk); rst = 1'b0;
   endtask

   // Presents each requester's queue head every cycle and logs handshakes.
   task automatic run_drive(input int budget);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (n < budget && !done) begin
         @(negedge clk);
         done = 1'b1;
         for (int r = 0; r < N_REQ; r++) begin
            if (dq[r].size() > 0) begin
               req_valid[r] = 1'b1;
               req_data[r*DATA_W +: DATA_W] = dq[r][0];
               req_last[r] = lq[r][0];
               done = 1'b0;
            end else begin
               req_valid[r] = 1'b0;
               req_data[r*DATA_W +: DATA_W] = '0;
               req_last[r] = 1'b0;
            end
         end
         for (int r = 0; r < N_REQ; r++) begin
            if (req_valid[r] && req_ready[r]) begin
               hs_id_q.push_back(r);
               hs_cyc_q.push_back(cyc);
               void'(dq[r].pop_front());
               void'(lq[r].pop_front());
            end
         end
         n++;
      end
      checks++;
      if (!done) begin
         fails++;
         $display("FAIL drive_timeout got=%0d cycles exp=<%0d", n, budget);
      end
      repeat (lat + 4) @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      checks++; if (silu_a_tvalid !== 1'b0) begin fails++; $display("FAIL reset_a_tvalid got=%b exp=0", silu_a_tvalid); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single_burst();
      logic [31:0] vin [4];
      logic [31:0] vexp [4];
      vin  = '{32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 32'h4000_0000};
      vexp = '{32'h3F3B_0000, 32'h0000_0000, 32'hBE8A_0000, 32'h3FE1_0000};
      clear_logs(); lat = 2;
      for (int k = 0; k < 4; k++) begin
         dq[0].push_back(vin[k]);
         lq[0].push_back(k == 3);
      end
      run_drive(100);
      checks++; if (rid_q.size() !== 4) begin fails++; $display("FAIL single_count got=%0d exp=4", rid_q.size()); end
      for (int i = 0; i < 4 && i < rid_q.size(); i++) begin
         checks++; if (rid_q[i] !== 0) begin fails++; $display("FAIL single_id[%0d] got=%0d exp=0", i, rid_q[i]); end
         checks++; if (rdata_q[i] !== vexp[i]) begin fails++; $display("FAIL single_data[%0d] got=%h exp=%h", i, rdata_q[i], vexp[i]); end
         checks++; if (rlast_q[i] !== (i == 3)) begin fails++; $display("FAIL single_last[%0d] got=%b exp=%b", i, rlast_q[i], i == 3); end
      end
      if (rcyc_q.size() > 0 && hs_cyc_q.size() > 0) begin
         checks++;
         if (rcyc_q[0] - hs_cyc_q[0] !== lat + 2) begin
            fails++; $display("FAIL single_latency got=%0d exp=%0d", rcyc_q[0] - hs_cyc_q[0], lat + 2);
         end
      end
   endtask

   task automatic test_round_robin();
      int order [6];
      int r, k;
      order = '{0, 1, 3, 0, 1, 3};
      do_reset(); clear_logs(); lat = 2;
      load(0, 6, 3); load(1, 6, 3); load(3, 6, 3);
      run_drive(200);
      checks++; if (rid_q.size() !== 18) begin fails++; $display("FAIL rr_count got=%0d exp=18", rid_q.size()); end
      for (int i = 0; i < 12 && i < hs_id_q.size(); i++) begin
         checks++;
         if (hs_id_q[i] !== order[i/3]) begin fails++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, hs_id_q[i], order[i/3]); end
      end
      for (int i = 0; i < 18 && i < rid_q.size(); i++) begin
         r = order[i/3];
         k = (i / 9) * 3 + i % 3;
         checks++;
         if (rid_q[i] !== r || rdata_q[i] !== mk(r, k) || rlast_q[i] !== (i % 3 == 2)) begin
            fails++; $display("FAIL rr_resp[%0d] got=%0d/%h/%b exp=%0d/%h/%b", i, rid_q[i], rdata_q[i], rlast_q[i], r, mk(r, k), i % 3 == 2);
         end
      end
      for (int i = 1; i < 18 && i < a_cyc_q.size(); i++) begin
         checks++;
         if (a_cyc_q[i] - a_cyc_q[i-1] !== ((i % 3 == 0) ? 2 : 1)) begin
            fails++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", i, a_cyc_q[i] - a_cyc_q[i-1], (i % 3 == 0) ? 2 : 1);
         end
      end
   endtask

   task automatic test_backpressure();
      int t0;
      do_reset(); clear_logs(); lat = 10;
      load(0, 12, 12);
      run_drive(300);
      checks++; if (hs_cyc_q.size() !== 12) begin fails++; $display("FAIL bp_hs_count got=%0d exp=12", hs_cyc_q.size()); end
      if (hs_cyc_q.size() >= 5) begin
         t0 = hs_cyc_q[0];
         checks++; if (hs_cyc_q[3] - t0 !== 3) begin fails++; $display("FAIL bp_first4 got=%0d exp=3", hs_cyc_q[3] - t0); end
         checks++; if (hs_cyc_q[4] - t0 !== 12) begin fails++; $display("FAIL bp_resume got=%0d exp=12", hs_cyc_q[4] - t0); end
         checks++; if (rdy_log[(t0+4) % 8192][0] !== 1'b0) begin fails++; $display("FAIL bp_ready_drop got=%b exp=0", rdy_log[(t0+4) % 8192][0]); end
         checks++; if (rdy_log[(t0+11) % 8192][0] !== 1'b0) begin fails++; $display("FAIL bp_ready_held got=%b exp=0", rdy_log[(t0+11) % 8192][0]); end
         checks++; if (rdy_log[(t0+12) % 8192][0] !== 1'b1) begin fails++; $display("FAIL bp_ready_back got=%b exp=1", rdy_log[(t0+12) % 8192][0]); end
      end
      checks++; if (rid_q.size() !== 12) begin fails++; $display("FAIL bp_count got=%0d exp=12", rid_q.size()); end
      for (int i = 0; i < 12 && i < rid_q.size(); i++) begin
         checks++;
         if (rid_q[i] !== 0 || rdata_q[i] !== mk(0, i) || rlast_q[i] !== (i == 11)) begin
            fails++; $display("FAIL bp_resp[%0d] got=%0d/%h/%b exp=0/%h/%b", i, rid_q[i], rdata_q[i], rlast_q[i], mk(0, i), i == 11);
         end
      end
      checks++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL bp_err got=%b exp=0", err_underflow); end
   endtask

   task automatic test_stream();
      int t0, bad;
      do_reset(); clear_logs(); lat = 2;
      load(2, 64, 64);
      run_drive(300);
      checks++; if (rid_q.size() !== 64) begin fails++; $display("FAIL stream_count got=%0d exp=64", rid_q.size()); end
      bad = 0;
      for (int i = 0; i < 64 && i < rid_q.size(); i++) begin
         if (rid_q[i] !== 2 || rdata_q[i] !== mk(2, i) || rlast_q[i] !== (i == 63)) bad++;
      end
      checks++; if (bad !== 0) begin fails++; $display("FAIL stream_resp got=%0d bad exp=0", bad); end
      if (hs_cyc_q.size() == 64) begin
         t0 = hs_cyc_q[0];
         checks++; if (hs_cyc_q[63] - t0 !== 63) begin fails++; $display("FAIL stream_rate got=%0d exp=63", hs_cyc_q[63] - t0); end
         bad = 0;
         for (int c = t0 + lat + 1; c <= t0 + 63; c++) if (tc_log[c % 8192] !== lat + 1) bad++;
         checks++; if (bad !== 0) begin fails++; $display("FAIL stream_tag_count got=%0d off-level cycles exp=0", bad); end
      end
   endtask

   task automatic test_reset_mid_burst();
      int n_hs;
      do_reset(); clear_logs(); lat = 2;
      @(negedge clk);
      req_valid = 4'b0100; req_last = '0;
      req_data[2*DATA_W +: DATA_W] = mk(2, 7);
      n_hs = 0;
      for (int c = 0; c < 10 && n_hs < 2; c++) begin
         @(negedge clk);
         if (req_ready[2]) n_hs++;
      end
      checks++; if (n_hs !== 2) begin fails++; $display("FAIL mid_start got=%0d exp=2", n_hs); end
      @(negedge clk);
      checks++; if (silu_a_tvalid !== 1'b1) begin fails++; $display("FAIL mid_active got=%b exp=1", silu_a_tvalid); end
      rst = 1'b1;
      #1;
      clear_logs();
      checks++; if (req_ready !== '0) begin fails++; $display("FAIL mid_req_ready got=%b exp=0", req_ready); end
      checks++; if ({silu_a_tvalid, silu_a_tdata} !== '0) begin fails++; $display("FAIL mid_a got=%b/%h exp=0", silu_a_tvalid, silu_a_tdata); end
      checks++; if ({resp_valid, resp_id, resp_data, resp_last} !== '0) begin fails++; $display("FAIL mid_resp got=%b/%0d/%h/%b exp=0", resp_valid, resp_id, resp_data, resp_last); end
      checks++; if ({busy, err_underflow} !== 2'b00) begin fails++; $display("FAIL mid_flags got=%b%b exp=00", busy, err_underflow); end
      checks++; if (dut.state !== 1'b0) begin fails++; $display("FAIL mid_state got=%b exp=0", dut.state); end
      req_valid = 4'b0101;
      req_data[0 +: DATA_W] = mk(0, 9);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_regrant got=%b exp=0001", req_ready); end
      req_last[0] = 1'b1;
      @(negedge clk);
      req_valid = '0; req_last = '0;
      repeat (lat + 4) @(negedge clk);
      checks++;
      if (rid_q.size() !== 1 || (rid_q.size() > 0 && (rid_q[0] !== 0 || rdata_q[0] !== mk(0, 9)))) begin
         fails++; $display("FAIL mid_after got=%0d resp exp=1 resp id 0 data %h", rid_q.size(), mk(0, 9));
      end
   endtask

   task automatic test_underflow();
      @(negedge clk);
      checks++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL uf_pre got=%b exp=0", err_underflow); end
      force_res = 1'b1;
      @(negedge clk);
      force_res = 1'b0;
      checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL uf_resp got=%b exp=0", resp_valid); end
      repeat (3) @(negedge clk);
      checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL uf_resp_late got=%b exp=0", resp_valid); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_backpressure();
      test_stream();
      test_reset_mid_burst();
      test_underflow();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
